vend_seq: RTL and testbench

VEND_SEQ -- requirements
Module: vend_seq

---
 rtl/vend_pkg.sv | 35 +++
 rtl/vend_credit.sv | 44 ++++
 rtl/vend_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_vend_seq.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
// Optional feature macro: VEND_CHANGE_RETURN_EN (change payout and cancel refund).
package vend_pkg;

   // Sequencer states. The CHANGE state exists only when change return is built in.
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CREDIT   = 3'd1,
      S_DISPENSE = 3'd2,
`ifdef VEND_CHANGE_RETURN_EN
      S_CHANGE   = 3'd3,
`endif
      S_FAULT    = 3'd4
   } vend_state_e;

   // Per-cycle coin codes.
   localparam logic [1:0] COIN_NONE = 2'd0;
   localparam logic [1:0] COIN_ONE  = 2'd1;
   localparam logic [1:0] COIN_TWO  = 2'd2;
   localparam logic [1:0] COIN_BAD  = 2'd3;

   // Product identifiers as driven on disp_id.
   localparam logic PROD_A = 1'b0;
   localparam logic PROD_B = 1'b1;

   // Value of a coin code in coin units (0 for none/invalid).
   function automatic logic [1:0] coin_units(input logic [1:0] code);
      logic [1:0] units;
      units = 2'd0;
      if (code == COIN_ONE) units = 2'd1;
      if (code == COIN_TWO) units = 2'd2;
      return units;
   endfunction

endpackage

// File: rtl/vend_credit.sv
// Credit accumulator for the vending sequencer.
// Adds accepted coins only when the sum fits in CRED_W bits, subtracts the
// product price after a dispense, and clears after change payout.
module vend_credit
   import vend_pkg::*;
#(
   parameter int CRED_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_add_en,
   input  logic [1:0]        i_add_amt,
   input  logic              i_sub_en,
   input  logic [CRED_W-1:0] i_sub_amt,
   input  logic              i_clr,
   output logic [CRED_W-1:0] o_credit,
   output logic [CRED_W-1:0] o_remain,
   output logic              o_add_fits
);

   logic [CRED_W-1:0] r_credit;
   logic [CRED_W:0]   w_sum;

   // One extra bit on the sum exposes an overflow without wrapping.
   assign w_sum      = {1'b0, r_credit} + {{(CRED_W-1){1'b0}}, i_add_amt};
   assign o_add_fits = ~w_sum[CRED_W];
   // The sequencer only subtracts after checking credit >= price.
   assign o_remain   = r_credit - i_sub_amt;
   assign o_credit   = r_credit;

   // Credit register: clear beats subtract beats add.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credit <= '0;
      end else if (i_clr) begin
         r_credit <= '0;
      end else if (i_sub_en) begin
         r_credit <= o_remain;
      end else if (i_add_en && o_add_fits) begin
         r_credit <= w_sum[CRED_W-1:0];
      end
   end

endmodule

// File: rtl/vend_seq.sv
// Vending machine transaction sequencer.
// Optional feature macro: VEND_CHANGE_RETURN_EN. When defined, a non-zero
// remainder after dispense and a cancel in CREDIT are paid out through the
// chg_valid/chg_ready handshake. When undefined, there is no CHANGE state,
// cancel is ignored and any remainder stays as credit.
//
// Handshakes: disp_req/disp_id are held stable from the cycle after a
// purchase is accepted until the edge where disp_ack=1 is sampled;
// chg_valid/chg_amt are held stable until the edge where chg_ready=1 is
// sampled. All outputs are registered. dbg_state mirrors the state register.
module vend_seq
   import vend_pkg::*;
#(
   parameter int PRICE_A = 3,
   parameter int PRICE_B = 4,
   parameter int CRED_W  = 4,
   parameter int DISP_TO = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        coin,
   input  logic [1:0]        sel,
   input  logic              cancel,
   output logic              coin_rej,
   output logic [CRED_W-1:0] credit,
   output logic              disp_req,
   output logic              disp_id,
   input  logic              disp_ack,
   output logic              chg_valid,
   output logic [CRED_W-1:0] chg_amt,
   input  logic              chg_ready,
   output logic              busy,
   output logic              fault,
   output logic [2:0]        dbg_state
);

   localparam logic [CRED_W-1:0] L_PRICE_A = PRICE_A[CRED_W-1:0];
   localparam logic [CRED_W-1:0] L_PRICE_B = PRICE_B[CRED_W-1:0];
   localparam int                CNT_W     = (DISP_TO > 1) ? $clog2(DISP_TO) : 1;
   localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(DISP_TO - 1);

   vend_state_e       r_state;
   vend_state_e       w_state_nx;
   logic [CNT_W-1:0]  r_to_cnt;

   logic              r_coin_rej;
   logic              r_disp_req;
   logic              r_disp_id;
   logic              r_busy;
   logic              r_fault;

   logic              w_coin_rej_nx;
   logic              w_disp_req_nx;
   logic              w_disp_id_nx;
   logic              w_busy_nx;
   logic              w_fault_nx;

   logic [CRED_W-1:0] w_credit;
   logic [CRED_W-1:0] w_remain;
   logic [CRED_W-1:0] w_price;
   logic [1:0]        w_coin_amt;
   logic              w_add_fits;
   logic              w_coin_val;
   logic              w_in_accept;
   logic              w_sel_ok;
   logic              w_cancel_ok;
   logic              w_coin_ok;
   logic              w_ack;
   logic              w_timeout;
   logic              w_chg_done;

   // ------------------------------------------------------------------
   // Input decode shared by next-state and output logic
   // ------------------------------------------------------------------
   assign w_coin_amt  = coin_units(coin);
   assign w_coin_val  = (coin == COIN_ONE) || (coin == COIN_TWO);
   assign w_in_accept = (r_state == S_IDLE) || (r_state == S_CREDIT);

`ifdef VEND_CHANGE_RETURN_EN
   assign w_cancel_ok = (r_state == S_CREDIT) && cancel;
   assign w_chg_done  = (r_state == S_CHANGE) && chg_ready;
`else
   logic w_unused_chg;
   assign w_cancel_ok  = 1'b0;
   assign w_chg_done   = 1'b0;
   assign w_unused_chg = ^{cancel, chg_ready};
`endif

   // sel=2'b11 is treated as A; a selection short of credit is ignored.
   assign w_sel_ok  = (r_state == S_CREDIT) && !w_cancel_ok &&
                      ((sel[0] && (w_credit >= L_PRICE_A)) ||
                       ((sel == 2'b10) && (w_credit >= L_PRICE_B)));
   // A coin is credited only when the machine is taking money, the sum
   // fits, and no purchase or refund is being accepted in the same cycle.
   assign w_coin_ok = w_in_accept && w_coin_val && w_add_fits && !w_sel_ok && !w_cancel_ok;
   assign w_ack     = (r_state == S_DISPENSE) && disp_ack;
   assign w_timeout = (r_state == S_DISPENSE) && !disp_ack && (r_to_cnt == TO_LAST);
   assign w_price   = (r_disp_id == PROD_B) ? L_PRICE_B : L_PRICE_A;

   vend_credit #(
      .CRED_W(CRED_W)
   ) u_credit (
      .clk       (clk),
      .rst       (rst),
      .i_add_en  (w_coin_ok),
      .i_add_amt (w_coin_amt),
      .i_sub_en  (w_ack),
      .i_sub_amt (w_price),
      .i_clr     (w_chg_done),
      .o_credit  (w_credit),
      .o_remain  (w_remain),
      .o_add_fits(w_add_fits)
   );

   // ------------------------------------------------------------------
   // State register, dispense timeout counter and registered outputs
   // ------------------------------------------------------------------
   // Advance the FSM, count dispense cycles and register the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_to_cnt   <= '0;
         r_coin_rej <= 1'b0;
         r_disp_req <= 1'b0;
         r_disp_id  <= PROD_A;
         r_busy     <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         if ((r_state == S_DISPENSE) && !w_ack && !w_timeout) begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
         end else begin
            r_to_cnt <= '0;
         end
         r_coin_rej <= w_coin_rej_nx;
         r_disp_req <= w_disp_req_nx;
         r_disp_id  <= w_disp_id_nx;
         r_busy     <= w_busy_nx;
         r_fault    <= w_fault_nx;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // Choose the next transaction state from the current one and the inputs.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_coin_ok) w_state_nx = S_CREDIT;
         end
         S_CREDIT: begin
`ifdef VEND_CHANGE_RETURN_EN
            if (w_cancel_ok) w_state_nx = S_CHANGE;
            else
`endif
            if (w_sel_ok) w_state_nx = S_DISPENSE;
         end
         S_DISPENSE: begin
            if (w_ack) begin
               if (w_remain == '0) begin
                  w_state_nx = S_IDLE;
               end else begin
`ifdef VEND_CHANGE_RETURN_EN
                  w_state_nx = S_CHANGE;
`else
                  w_state_nx = S_CREDIT;
`endif
               end
            end else if (w_timeout) begin
               w_state_nx = S_FAULT;
            end
         end
`ifdef VEND_CHANGE_RETURN_EN
         S_CHANGE: begin
            if (chg_ready) w_state_nx = S_IDLE;
         end
`endif
         S_FAULT: begin
            w_state_nx = S_FAULT;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // ------------------------------------------------------------------
   // Derive next output values from the next state and accepted events.
   always_comb begin
      w_coin_rej_nx = (coin != COIN_NONE) && !w_coin_ok;
      w_disp_req_nx = (w_state_nx == S_DISPENSE);
      w_disp_id_nx  = r_disp_id;
      if (w_sel_ok) begin
         w_disp_id_nx = sel[0] ? PROD_A : PROD_B;
      end
      w_fault_nx    = (w_state_nx == S_FAULT);
`ifdef VEND_CHANGE_RETURN_EN
      w_busy_nx     = (w_state_nx == S_DISPENSE) || (w_state_nx == S_CHANGE);
`else
      w_busy_nx     = (w_state_nx == S_DISPENSE);
`endif
   end

`ifdef VEND_CHANGE_RETURN_EN
   logic              r_chg_valid;
   logic [CRED_W-1:0] r_chg_amt;
   logic [CRED_W-1:0] w_chg_amt_nx;

   // Change amount: full credit on cancel, remainder after dispense, else held.
   always_comb begin
      w_chg_amt_nx = '0;
      if (w_state_nx == S_CHANGE) begin
         if (w_cancel_ok) begin
            w_chg_amt_nx = w_credit;
         end else if (w_ack) begin
            w_chg_amt_nx = w_remain;
         end else begin
            w_chg_amt_nx = r_chg_amt;
         end
      end
   end

   // Change offer registers, held until the payout handshake completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chg_valid <= 1'b0;
         r_chg_amt   <= '0;
      end else begin
         r_chg_valid <= (w_state_nx == S_CHANGE);
         r_chg_amt   <= w_chg_amt_nx;
      end
   end

   assign chg_valid = r_chg_valid;
   assign chg_amt   = r_chg_amt;
`else
   assign chg_valid = 1'b0;
   assign chg_amt   = '0;
`endif

   assign coin_rej  = r_coin_rej;
   assign credit    = w_credit;
   assign disp_req  = r_disp_req;
   assign disp_id   = r_disp_id;
   assign busy      = r_busy;
   assign fault     = r_fault;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_vend_seq.sv
// Testbench for vend_seq: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the vending rules.
module tb_vend_seq;

  localparam int PRICE_A  = 3;
  localparam int PRICE_B  = 4;
  localparam int CRED_W   = 4;
  localparam int DISP_TO  = 255;
  localparam int CRED_MAX = (1 << CRED_W) - 1;
  localparam int OW       = 4 + 2 * CRED_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        coin = 2'd0;
  logic [1:0]        sel = 2'd0;
  logic              cancel = 1'b0;
  logic              disp_ack = 1'b0;
  logic              chg_ready = 1'b0;
  logic              coin_rej;
  logic [CRED_W-1:0] credit;
  logic              disp_req;
  logic              disp_id;
  logic              chg_valid;
  logic [CRED_W-1:0] chg_amt;
  logic              busy;
  logic              fault;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  vend_seq #(
    .PRICE_A(PRICE_A), .PRICE_B(PRICE_B), .CRED_W(CRED_W), .DISP_TO(DISP_TO)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .coin_rej(coin_rej), .credit(credit), .disp_req(disp_req), .disp_id(disp_id),
    .disp_ack(disp_ack), .chg_valid(chg_valid), .chg_amt(chg_amt),
    .chg_ready(chg_ready), .busy(busy), .fault(fault), .dbg_state(dbg_state)
  );

  logic [OW-1:0] obs;
  assign obs = {coin_rej, credit, disp_req, disp_id, chg_valid, chg_amt, busy, fault};

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Transaction view: money held, whether a product is being dispensed,
  // whether change is being paid out, and whether the machine is dead.
  int m_credit;
  bit m_disp;
  bit m_chg;
  bit m_fault;
  bit m_rej;
  bit m_id;
  int m_wait;

  task automatic model_reset();
    m_credit = 0; m_disp = 0; m_chg = 0; m_fault = 0; m_rej = 0; m_id = 0; m_wait = 0;
  endtask

  function automatic int price_of(input bit id);
    return id ? PRICE_B : PRICE_A;
  endfunction

  task automatic model_cycle(input logic r, input logic [1:0] c, input logic [1:0] s,
                             input logic cn, input logic ak, input logic rd);
    int amt;
    bit took;
    if (r) begin
      model_reset();
      return;
    end
    m_rej = 0;
    amt = (c == 2'd1) ? 1 : ((c == 2'd2) ? 2 : 0);
    if (m_fault) begin
      m_rej = (c != 2'd0);
    end else if (m_disp) begin
      m_rej = (c != 2'd0);
      if (ak) begin
        m_credit = m_credit - price_of(m_id);
        m_disp = 0;
        m_wait = 0;
`ifdef VEND_CHANGE_RETURN_EN
        if (m_credit > 0) m_chg = 1;
`endif
      end else begin
        m_wait++;
        if (m_wait == DISP_TO) begin
          m_fault = 1;
          m_disp = 0;
        end
      end
    end else if (m_chg) begin
      m_rej = (c != 2'd0);
      if (rd) begin
        m_credit = 0;
        m_chg = 0;
      end
    end else begin
      took = 0;
`ifdef VEND_CHANGE_RETURN_EN
      if (cn && m_credit > 0) begin
        m_chg = 1;
        took = 1;
      end
`endif
      if (!took && m_credit > 0 && s != 2'd0) begin
        if (m_credit >= price_of(!s[0])) begin
          m_id = !s[0];
          m_disp = 1;
          m_wait = 0;
          took = 1;
        end
      end
      if (amt > 0) begin
        if (took || (m_credit + amt > CRED_MAX)) m_rej = 1;
        else m_credit = m_credit + amt;
      end else if (c == 2'd3) begin
        m_rej = 1;
      end
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [CRED_W-1:0] c;
    logic [CRED_W-1:0] a;
    c = m_credit[CRED_W-1:0];
    a = m_chg ? c : {CRED_W{1'b0}};
    return {m_rej, c, m_disp, m_id, m_chg, a, (m_disp | m_chg), m_fault};
  endfunction

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input logic r, input logic [1:0] c, input logic [1:0] s,
                      input logic cn, input logic ak, input logic rd);
    rst = r; coin = c; sel = s; cancel = cn; disp_ack = ak; chg_ready = rd;
    @(posedge clk);
    model_cycle(r, c, s, cn, ak, rd);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 2'd2, 2'd1, 1, 1, 1);
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs, {OW{1'b0}});
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs !== model_out()) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, model_out());
    end
  endtask

  task automatic test_buy_a();
    logic [1:0] coins [2] = '{2'd1, 2'd2};
    step(1, 0, 0, 0, 0, 0);
    foreach (coins[i]) begin
      step(0, coins[i], 0, 0, 0, 0);
      n_tests++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL buy_a_coin%0d: got %h expected %h", i, obs, model_out());
      end
    end
    n_tests++;
    if (credit !== 4'd3) begin
      n_fail++;
      $display("FAIL buy_a_credit: got %0d expected 3", credit);
    end
    step(0, 0, 2'b01, 0, 0, 0);
    n_tests++;
    if ({disp_req, disp_id, credit, busy} !== {1'b1, 1'b0, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL buy_a_dispense: got req=%b id=%b credit=%0d busy=%b expected 1 0 3 1",
               disp_req, disp_id, credit, busy);
    end
    step(0, 0, 0, 0, 1, 0);
    n_tests++;
    if ({disp_req, credit, chg_valid, busy} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL buy_a_ack: got req=%b credit=%0d chg_valid=%b busy=%b expected 0 0 0 0",
               disp_req, credit, chg_valid, busy);
    end
  endtask

  task automatic test_buy_b_change();
    logic [1:0] coins [3] = '{2'd2, 2'd2, 2'd1};
    step(1, 0, 0, 0, 0, 0);
    foreach (coins[i]) step(0, coins[i], 0, 0, 0, 0);
    step(0, 0, 2'b10, 0, 0, 0);
    n_tests++;
    if ({disp_req, disp_id, credit} !== {1'b1, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL buy_b_dispense: got req=%b id=%b credit=%0d expected 1 1 5", disp_req, disp_id, credit);
    end
    // ack held for two cycles: the second one lands outside DISPENSE
    step(0, 0, 0, 0, 1, 0);
    n_tests++;
    if (credit !== 4'd1 || disp_req !== 1'b0) begin
      n_fail++;
      $display("FAIL buy_b_remainder: got credit=%0d req=%b expected 1 0", credit, disp_req);
    end
`ifdef VEND_CHANGE_RETURN_EN
    n_tests++;
    if ({chg_valid, chg_amt, busy} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL buy_b_change_offer: got valid=%b amt=%0d busy=%b expected 1 1 1", chg_valid, chg_amt, busy);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    n_tests++;
    if ({chg_valid, credit, busy} !== {1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL buy_b_change_done: got valid=%b credit=%0d busy=%b expected 0 0 0", chg_valid, credit, busy);
    end
`else
    n_tests++;
    if ({chg_valid, chg_amt, busy} !== {1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL buy_b_no_change: got valid=%b amt=%0d busy=%b expected 0 0 0", chg_valid, chg_amt, busy);
    end
    step(0, 0, 0, 0, 1, 1);
    n_tests++;
    if (obs !== model_out() || credit !== 4'd1) begin
      n_fail++;
      $display("FAIL buy_b_stray_ack: got %h expected %h", obs, model_out());
    end
`endif
  endtask

  task automatic test_insufficient();
    step(1, 0, 0, 0, 0, 0);
    step(0, 2'd1, 0, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    n_tests++;
    if ({disp_req, credit, busy} !== {1'b0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL insufficient_sel: got req=%b credit=%0d busy=%b expected 0 1 0", disp_req, credit, busy);
    end
    step(0, 0, 2'b01, 1, 0, 0);
    n_tests++;
`ifdef VEND_CHANGE_RETURN_EN
    if ({chg_valid, chg_amt, disp_req} !== {1'b1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL cancel_refund: got valid=%b amt=%0d req=%b expected 1 1 0", chg_valid, chg_amt, disp_req);
    end
`else
    if ({chg_valid, credit, disp_req} !== {1'b0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL cancel_ignored: got valid=%b credit=%0d req=%b expected 0 1 0", chg_valid, credit, disp_req);
    end
`endif
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 2'd2, 0, 0, 0, 0);
    n_tests++;
    if (credit !== 4'd14 || coin_rej !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_fill: got credit=%0d rej=%b expected 14 0", credit, coin_rej);
    end
    step(0, 2'd2, 0, 0, 0, 0);
    n_tests++;
    if ({coin_rej, credit} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL overflow_reject: got rej=%b credit=%0d expected 1 14", coin_rej, credit);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if (coin_rej !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_rej_pulse: got rej=%b expected 0", coin_rej);
    end
    step(0, 2'd3, 0, 0, 0, 0);
    n_tests++;
    if ({coin_rej, credit} !== {1'b1, 4'd14}) begin
      n_fail++;
      $display("FAIL invalid_coin: got rej=%b credit=%0d expected 1 14", coin_rej, credit);
    end
    step(0, 2'd1, 0, 0, 0, 0);
    step(0, 2'd1, 0, 0, 0, 0);
    n_tests++;
    if ({coin_rej, credit} !== {1'b1, 4'd15}) begin
      n_fail++;
      $display("FAIL overflow_at_max: got rej=%b credit=%0d expected 1 15", coin_rej, credit);
    end
  endtask

  task automatic test_coin_with_sel();
    step(1, 0, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 2'd1, 2'b11, 0, 0, 0);
    n_tests++;
    if ({coin_rej, credit, disp_req, disp_id} !== {1'b1, 4'd4, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL coin_with_sel: got rej=%b credit=%0d req=%b id=%b expected 1 4 1 0",
               coin_rej, credit, disp_req, disp_id);
    end
    step(0, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== model_out() || credit !== 4'd1) begin
      n_fail++;
      $display("FAIL coin_with_sel_ack: got %h expected %h", obs, model_out());
    end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    for (int i = 1; i < DISP_TO; i++) begin
      step(0, (i == 10) ? 2'd1 : 2'd0, 0, 0, 0, 0);
      n_tests++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got %h expected %h", i, obs, model_out());
      end
    end
    n_tests++;
    if ({disp_req, fault} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_early: got req=%b fault=%b expected 1 0", disp_req, fault);
    end
    step(0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({fault, disp_req, credit, busy} !== {1'b1, 1'b0, 4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_fault: got fault=%b req=%b credit=%0d busy=%b expected 1 0 4 0",
               fault, disp_req, credit, busy);
    end
    step(0, 2'd1, 2'b01, 1, 1, 1);
    n_tests++;
    if ({coin_rej, fault, credit, disp_req} !== {1'b1, 1'b1, 4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL fault_sticky: got rej=%b fault=%b credit=%0d req=%b expected 1 1 4 0",
               coin_rej, fault, credit, disp_req);
    end
    step(1, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL fault_reset: got %h expected %h", obs, {OW{1'b0}});
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 0, 2'b01, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_dispense: got %h expected %h", obs, {OW{1'b0}});
    end
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 2'd2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    n_tests++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_change: got %h expected %h", obs, {OW{1'b0}});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c_t [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [1:0] s_t [8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
    logic       a_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       r_t [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, c_t[i], s_t[i], 0, a_t[i], r_t[i]);
      n_tests++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL back_to_back%0d: got %h expected %h", i, obs, model_out());
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] c;
    logic [1:0] s;
    logic       cn;
    logic       ak;
    logic       rd;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cn = ($urandom_range(0, 15) == 0);
      ak = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 2) == 0);
      step(r, c, s, cn, ak, rd);
      n_tests++;
      if (obs !== model_out()) begin
        n_fail++;
        $display("FAIL random%0d: got %h expected %h", i, obs, model_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_buy_a();
    test_buy_b_change();
    test_insufficient();
    test_overflow();
    test_coin_with_sel();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
